// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared types and helper functions for the branch predictor table.
//   cnt_reset(cntW)   : weakly-not-taken reset value for a cntW-bit counter
//   sat_inc/sat_dec   : saturating step of a counter value
//   idx_of(pc, idxW)  : word-aligned table index slice pc[idxW+1:2]
// Helpers operate on maximum-width containers so they can serve every
// legal parameterisation; callers size-cast the result to their own width.
// ---------------------------------------------------------------------------
package bp_pkg;

    localparam int unsigned CNT_MAX_W = 4;
    localparam int unsigned IDX_MAX_W = 8;
    localparam int unsigned PC_MAX_W  = 64;

    typedef logic [CNT_MAX_W-1:0] cnt_t;
    typedef logic [IDX_MAX_W-1:0] idx_t;
    typedef logic [PC_MAX_W-1:0]  pc_t;

    function automatic cnt_t cnt_reset(input int unsigned cntW);
        return cnt_t'((32'd1 << (cntW - 32'd1)) - 32'd1);
    endfunction

    function automatic cnt_t sat_inc(input cnt_t c, input int unsigned cntW);
        int unsigned lim;
        lim = (32'd1 << cntW) - 32'd1;
        if ({28'd0, c} >= lim) begin
            return c;
        end
        return c + cnt_t'(1);
    endfunction

    function automatic cnt_t sat_dec(input cnt_t c, input int unsigned cntW);
        if (c == '0 || cntW == 0) begin
            return c;
        end
        return c - cnt_t'(1);
    endfunction

    function automatic idx_t idx_of(input pc_t pc, input int unsigned idxW);
        idx_t mask;
        mask = idx_t'((32'd1 << idxW) - 32'd1);
        return idx_t'(pc >> 2) & mask;
    endfunction

endpackage

// File: rtl/bp_table_if.sv
// ---------------------------------------------------------------------------
// bp_table_if
// Request/prediction/update bundle between fetch, resolve and the predictor.
//   req_valid, req_pc            : prediction request from fetch
//   pred_valid, pred_taken,
//   pred_idx                     : registered prediction back to fetch
//   upd_valid, upd_idx, upd_taken: resolved outcome from execute
//   perf_mispred                 : saturating mispredict count
// master = fetch/execute side, slave = the predictor table.
// ---------------------------------------------------------------------------
interface bp_table_if #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned PERF_W = 16
);

    logic              req_valid;
    logic [PC_W-1:0]   req_pc;
    logic              pred_valid;
    logic              pred_taken;
    logic [IDX_W-1:0]  pred_idx;
    logic              upd_valid;
    logic [IDX_W-1:0]  upd_idx;
    logic              upd_taken;
    logic [PERF_W-1:0] perf_mispred;

    modport master (
        output req_valid, req_pc, upd_valid, upd_idx, upd_taken,
        input  pred_valid, pred_taken, pred_idx, perf_mispred
    );

    modport slave (
        input  req_valid, req_pc, upd_valid, upd_idx, upd_taken,
        output pred_valid, pred_taken, pred_idx, perf_mispred
    );

endinterface

// File: rtl/bp_sat_ctr.sv
// ---------------------------------------------------------------------------
// bp_sat_ctr
// One CNT_W-bit saturating counter, reset to weakly-not-taken.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc_i      : step up (saturates at all-ones)
//   dec_i      : step down (saturates at zero); ignored when inc_i is high
//   cnt_o      : current counter value
//   msb_o      : counter MSB, i.e. the taken prediction
// ---------------------------------------------------------------------------
module bp_sat_ctr
    import bp_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             msb_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next counter value; the package helpers clamp at both ends.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = CNT_W'(sat_inc(cnt_t'(cnt_q), CNT_W));
        end else if (dec_i) begin
            cnt_d = CNT_W'(sat_dec(cnt_t'(cnt_q), CNT_W));
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_W'(cnt_reset(CNT_W));
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign msb_o = cnt_q[CNT_W-1];

endmodule

// File: rtl/bp_table.sv
// ---------------------------------------------------------------------------
// bp_table
// Table of 2^IDX_W saturating counters indexed by the branch PC, with a
// 1-cycle registered prediction, same-cycle outcome update and a saturating
// mispredict counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bp_table_if.slave (request, prediction, update, perf)
// Optional feature, macro BP_GSHARE_EN: the request index is XORed with a
// global history register of HIST_W outcome bits (gshare). Without it the
// table is purely bimodal and HIST_W only takes part in the config check.
// ---------------------------------------------------------------------------
module bp_table
    import bp_pkg::*;
#(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned HIST_W = 4,
    parameter int unsigned PERF_W = 16
) (
    input logic        clk,
    input logic        rst_n,
    bp_table_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    // Reject parameterisations the index/counter helpers cannot represent.
    if (IDX_W < 1 || IDX_W > IDX_MAX_W || CNT_W < 1 || CNT_W > CNT_MAX_W ||
        HIST_W < 1 || HIST_W > IDX_W || PC_W < IDX_W + 2 || PC_W > PC_MAX_W ||
        PERF_W < 1) begin : g_bad_cfg
        $error("bp_table: illegal parameter combination");
    end

    logic [CNT_W-1:0] ctrVal [DEPTH];
    logic [DEPTH-1:0] ctrMsb;
    logic [DEPTH-1:0] ctrInc;
    logic [DEPTH-1:0] ctrDec;

    logic [IDX_W-1:0]  pcIdx;
    logic [IDX_W-1:0]  reqIdx;
    logic [CNT_W-1:0]  updCur;
    logic [CNT_W-1:0]  updPost;
    logic              bypass;
    logic              mispred;

    logic              predValid_q, predValid_d;
    logic              predTaken_q, predTaken_d;
    logic [IDX_W-1:0]  predIdx_q,   predIdx_d;
    logic [PERF_W-1:0] perf_q,      perf_d;

    // Counter array; each entry steps only when the update targets it.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ctr
        assign ctrInc[i] = bus.upd_valid &&  bus.upd_taken && (bus.upd_idx == IDX_W'(i));
        assign ctrDec[i] = bus.upd_valid && !bus.upd_taken && (bus.upd_idx == IDX_W'(i));

        bp_sat_ctr #(.CNT_W(CNT_W)) u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .inc_i (ctrInc[i]),
            .dec_i (ctrDec[i]),
            .cnt_o (ctrVal[i]),
            .msb_o (ctrMsb[i])
        );
    end

    assign pcIdx = IDX_W'(idx_of(pc_t'(bus.req_pc), IDX_W));

`ifdef BP_GSHARE_EN
    logic [HIST_W-1:0] ghr_q, ghr_d;

    // History shifts in each resolved outcome; requests never touch it.
    always_comb begin
        ghr_d = ghr_q;
        if (bus.upd_valid) begin
            ghr_d = HIST_W'({ghr_q, bus.upd_taken});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign reqIdx = pcIdx ^ IDX_W'(ghr_q);
`else
    assign reqIdx = pcIdx;
`endif

    // Post-update value of the counter being trained, so that a request to
    // the same index in the same cycle sees the trained value.
    assign updCur  = ctrVal[bus.upd_idx];
    assign updPost = bus.upd_taken ? CNT_W'(sat_inc(cnt_t'(updCur), CNT_W))
                                   : CNT_W'(sat_dec(cnt_t'(updCur), CNT_W));
    assign bypass  = bus.upd_valid && (bus.upd_idx == reqIdx);
    assign mispred = bus.upd_valid && (bus.upd_taken != ctrMsb[bus.upd_idx]);

    // Prediction and perf-counter next state; taken/idx hold when idle.
    always_comb begin
        predValid_d = bus.req_valid;
        predTaken_d = predTaken_q;
        predIdx_d   = predIdx_q;
        perf_d      = perf_q;
        if (bus.req_valid) begin
            predTaken_d = bypass ? updPost[CNT_W-1] : ctrMsb[reqIdx];
            predIdx_d   = reqIdx;
        end
        if (mispred && perf_q != '1) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    // Output and perf registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            predValid_q <= 1'b0;
            predTaken_q <= 1'b0;
            predIdx_q   <= '0;
            perf_q      <= '0;
        end else begin
            predValid_q <= predValid_d;
            predTaken_q <= predTaken_d;
            predIdx_q   <= predIdx_d;
            perf_q      <= perf_d;
        end
    end

    assign bus.pred_valid   = predValid_q;
    assign bus.pred_taken   = predTaken_q;
    assign bus.pred_idx     = predIdx_q;
    assign bus.perf_mispred = perf_q;

endmodule

// File: tb/tb_bp_table.sv
// ---------------------------------------------------------------------------
// tb_bp_table
// Directed plus short random stimulus for bp_table (IDX_W=4, CNT_W=2,
// PERF_W=2 so the mispredict counter saturation is reachable). A reference
// model of the counter table predicts each response; expected predictions
// are queued when a request is driven and popped when pred_valid returns.
// Honours BP_GSHARE_EN in the reference model when the macro is defined.
// ---------------------------------------------------------------------------
module tb_bp_table;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bp_table_if #(.PC_W(32), .IDX_W(4), .PERF_W(2)) bus ();

    bp_table #(
        .PC_W   (32),
        .IDX_W  (4),
        .CNT_W  (2),
        .HIST_W (4),
        .PERF_W (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       taken;
        logic [3:0] idx;
    } pred_t;

    pred_t      predQ [$];
    int         ctrModel [16];
    int         perfModel;
    logic [3:0] ghrModel;
    bit         expValid;
    int         assertCount = 0;
    int         failCount   = 0;

    function automatic int ctrNext(input int v, input bit t);
        if (t) return (v == 3) ? 3 : v + 1;
        return (v == 0) ? 0 : v - 1;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 16; i++) ctrModel[i] = 1;
        perfModel = 0;
        ghrModel  = '0;
        expValid  = 1'b0;
        predQ.delete();
    endtask

    // Compare registered outputs against the model after an edge.
    task automatic checkOutput();
        pred_t e;
        checkVal("pred_valid", {31'd0, bus.pred_valid}, {31'd0, expValid});
        if (expValid && predQ.size() > 0) begin
            e = predQ.pop_front();
            checkVal("pred_taken", {31'd0, bus.pred_taken}, {31'd0, e.taken});
            checkVal("pred_idx", {28'd0, bus.pred_idx}, {28'd0, e.idx});
        end
        checkVal("perf_mispred", {30'd0, bus.perf_mispred}, perfModel);
    endtask

    // One clock of request/update; model computes expectations pre-edge.
    task automatic applyStimulus(input bit rv, input logic [31:0] pc,
                                 input bit uv, input logic [3:0] ui, input bit ut);
        logic [31:0] pcv;
        logic [3:0]  idx;
        pred_t       e;
        int          v;
        @(negedge clk);
        bus.req_valid = rv;
        bus.req_pc    = pc;
        bus.upd_valid = uv;
        bus.upd_idx   = ui;
        bus.upd_taken = ut;
        pcv = pc;
        idx = pcv[5:2];
`ifdef BP_GSHARE_EN
        idx = idx ^ ghrModel;
`endif
        if (rv) begin
            v = ctrModel[idx];
            if (uv && ui == idx) v = ctrNext(v, ut);
            e.taken = (v >= 2);
            e.idx   = idx;
            predQ.push_back(e);
        end
        expValid = rv;
        if (uv) begin
            if (ut != (ctrModel[ui] >= 2)) perfModel = (perfModel == 3) ? 3 : perfModel + 1;
            ctrModel[ui] = ctrNext(ctrModel[ui], ut);
            ghrModel = {ghrModel[2:0], ut};
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_pc    = '0;
        bus.upd_valid = 1'b0;
        bus.upd_idx   = '0;
        bus.upd_taken = 1'b0;
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_pred_valid", {31'd0, bus.pred_valid}, 32'd0);
        checkVal("rst_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
        checkVal("rst_pred_idx", {28'd0, bus.pred_idx}, 32'd0);
        checkVal("rst_perf", {30'd0, bus.perf_mispred}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic request at idx 4, then idle.
        applyStimulus(1, 32'h10, 0, 4'd0, 0);
        checkVal("t1_idx", {28'd0, bus.pred_idx}, 32'd4);
        checkVal("t1_taken", {31'd0, bus.pred_taken}, 32'd0);
        applyStimulus(0, 32'h0, 0, 4'd0, 0);
        checkVal("t1_idle_valid", {31'd0, bus.pred_valid}, 32'd0);
        checkVal("t1_hold_idx", {28'd0, bus.pred_idx}, 32'd4);

        // Train idx 4 to strongly taken; only the first update mispredicts.
        repeat (3) applyStimulus(0, 32'h0, 1, 4'd4, 1);
        checkVal("t2_perf", {30'd0, bus.perf_mispred}, 32'd1);
        applyStimulus(1, 32'h10, 0, 4'd0, 0);
`ifndef BP_GSHARE_EN
        checkVal("t2_taken", {31'd0, bus.pred_taken}, 32'd1);
`endif

        // Walk idx 4 down to zero and past it.
        repeat (4) applyStimulus(0, 32'h0, 1, 4'd4, 0);
        checkVal("t3_perf_sat", {30'd0, bus.perf_mispred}, 32'd3);
        applyStimulus(1, 32'h10, 0, 4'd0, 0);
`ifndef BP_GSHARE_EN
        checkVal("t3_taken", {31'd0, bus.pred_taken}, 32'd0);
`endif

        // Same-cycle request and update: same index bypasses, other does not.
        applyStimulus(1, 32'h08, 1, 4'd2, 1);
`ifndef BP_GSHARE_EN
        checkVal("t4_bypass", {31'd0, bus.pred_taken}, 32'd1);
`endif
        applyStimulus(0, 32'h0, 1, 4'd2, 0);
        applyStimulus(1, 32'h08, 1, 4'd3, 1);
`ifndef BP_GSHARE_EN
        checkVal("t4_nobypass", {31'd0, bus.pred_taken}, 32'd0);
`endif
        checkVal("t4_perf_hold", {30'd0, bus.perf_mispred}, 32'd3);

        // Reset pulled while a request is in flight.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_pc    = 32'h10;
        bus.upd_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkVal("t5_in_reset_valid", {31'd0, bus.pred_valid}, 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        resetModel();
        @(posedge clk);
        #1;
        checkVal("t5_post_valid", {31'd0, bus.pred_valid}, 32'd0);
        checkVal("t5_perf", {30'd0, bus.perf_mispred}, 32'd0);
        applyStimulus(1, 32'h10, 0, 4'd0, 0);
        applyStimulus(1, 32'h0C, 0, 4'd0, 0);

        // Short random phase checked against the model.
        for (int n = 0; n < 40; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)));
        end
        applyStimulus(0, 32'h0, 0, 4'd0, 0);

`ifdef BP_GSHARE_EN
        // History T,T,N gives 0110; pc 0x04 hashes to 0111.
        @(negedge clk);
        rst_n = 1'b0;
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 32'h0, 1, 4'd0, 1);
        applyStimulus(0, 32'h0, 1, 4'd0, 1);
        applyStimulus(0, 32'h0, 1, 4'd0, 0);
        applyStimulus(1, 32'h04, 0, 4'd0, 0);
        checkVal("t6_hashed_idx", {28'd0, bus.pred_idx}, 32'h7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
